// File: rtl/matmul_csr_pkg.sv
// Shared constants for the matrix-multiply CSR block: register map, STATUS bits,
// CTRL field offsets derived from the dimension width, and the run-state encoding.
package matmul_csr_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CYCLES = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

    localparam int unsigned STAT_BUSY = 32'd0;
    localparam int unsigned STAT_DONE = 32'd1;
    localparam int unsigned STAT_ERR  = 32'd2;
    localparam int unsigned STAT_IRQ  = 32'd3;

    localparam int unsigned CTRL_START    = 32'd0;
    localparam int unsigned CTRL_MODE     = 32'd1;
    localparam int unsigned CTRL_WR_TGT   = 32'd2;
    localparam int unsigned CTRL_RD_TGT   = 32'd4;
    localparam int unsigned CTRL_DATAFLOW = 32'd6;
    localparam int unsigned CTRL_DIM_N    = 32'd8;

    function automatic int unsigned ctrl_dim_k(input int unsigned dim_w);
        return 32'd8 + dim_w;
    endfunction

    function automatic int unsigned ctrl_dim_m(input int unsigned dim_w);
        return 32'd8 + 32'd2 * dim_w;
    endfunction

    function automatic int unsigned ctrl_reload_a(input int unsigned dim_w);
        return 32'd8 + 32'd3 * dim_w;
    endfunction

    function automatic int unsigned ctrl_reload_b(input int unsigned dim_w);
        return 32'd9 + 32'd3 * dim_w;
    endfunction

    function automatic int unsigned ctrl_w(input int unsigned dim_w);
        return 32'd10 + 32'd3 * dim_w;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/matmul_csr_cycle_cnt.sv
// Saturating run-cycle counter; clear has priority over enable.
module matmul_csr_cycle_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: clear, then saturating increment.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (en_i && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/matmul_csr_ctrl.sv
// Host-facing CSR file for the matrix-multiply core: CTRL/STATUS/CYCLES/IRQ_EN,
// launch pulse generation, configuration lock while running, and done interrupt.
module matmul_csr_ctrl
    import matmul_csr_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DIM_W  = 2,
    parameter  int unsigned CNT_W  = 32,
    localparam int unsigned CTRL_W = ctrl_w(DIM_W)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              wr_err_o,
    input  logic              done_i,
    output logic              start_o,
    output logic              busy_o,
    output logic [CTRL_W-1:0] cfg_o,
    output logic              irq_o
);

    state_e            state_r, state_s;
    logic [CTRL_W-1:0] ctrl_r;
    logic              done_sticky_r, err_sticky_r, irq_en_r, irq_r;
    logic              start_r, wr_err_r, rvalid_r;
    logic [DATA_W-1:0] rdata_r, rd_mux_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              ctrl_wr_s, status_wr_s, irq_en_wr_s, busy_s;
    logic              launch_s, finish_s, reject_s, ctrl_load_s;
    logic              unused_wdata_s;

    assign ctrl_wr_s      = wr_en_i && (addr_i == ADDR_CTRL);
    assign status_wr_s    = wr_en_i && (addr_i == ADDR_STATUS);
    assign irq_en_wr_s    = wr_en_i && (addr_i == ADDR_IRQ_EN);
    assign busy_s         = (state_r == RUN);
    assign unused_wdata_s = ^wdata_i;

    // Next-state and write-acceptance decisions, based on the current state only.
    always_comb begin
        state_s     = state_r;
        launch_s    = 1'b0;
        finish_s    = 1'b0;
        reject_s    = 1'b0;
        ctrl_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ctrl_wr_s) begin
                    ctrl_load_s = 1'b1;
                    if (wdata_i[CTRL_START]) begin
                        launch_s = 1'b1;
                        state_s  = RUN;
                    end else begin
                        state_s  = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                reject_s = ctrl_wr_s;
                if (done_i) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s  = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, CTRL, sticky flags, interrupt and pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r       <= IDLE;
            ctrl_r        <= '0;
            done_sticky_r <= 1'b0;
            err_sticky_r  <= 1'b0;
            irq_en_r      <= 1'b0;
            irq_r         <= 1'b0;
            start_r       <= 1'b0;
            wr_err_r      <= 1'b0;
        end else begin
            state_r  <= state_s;
            start_r  <= launch_s;
            wr_err_r <= reject_s;
            irq_r    <= done_sticky_r & irq_en_r;
            if (ctrl_load_s) begin
                ctrl_r <= wdata_i[CTRL_W-1:0];
            end else if (finish_s) begin
                ctrl_r[CTRL_START] <= 1'b0;
            end else begin
                ctrl_r <= ctrl_r;
            end
            // Set beats a coincident write-1-to-clear.
            if (finish_s) begin
                done_sticky_r <= 1'b1;
            end else if (launch_s || (status_wr_s && wdata_i[STAT_DONE])) begin
                done_sticky_r <= 1'b0;
            end else begin
                done_sticky_r <= done_sticky_r;
            end
            if (reject_s) begin
                err_sticky_r <= 1'b1;
            end else if (status_wr_s && wdata_i[STAT_ERR]) begin
                err_sticky_r <= 1'b0;
            end else begin
                err_sticky_r <= err_sticky_r;
            end
            if (irq_en_wr_s) begin
                irq_en_r <= wdata_i[0];
            end else begin
                irq_en_r <= irq_en_r;
            end
        end
    end

    // Read multiplexer over the pre-write register values.
    always_comb begin
        rd_mux_s = '0;
        case (addr_i)
            ADDR_CTRL:   rd_mux_s[CTRL_W-1:0] = ctrl_r;
            ADDR_STATUS: begin
                rd_mux_s[STAT_BUSY] = busy_s;
                rd_mux_s[STAT_DONE] = done_sticky_r;
                rd_mux_s[STAT_ERR]  = err_sticky_r;
                rd_mux_s[STAT_IRQ]  = irq_r;
            end
            ADDR_CYCLES: rd_mux_s[CNT_W-1:0] = cnt_s;
            ADDR_IRQ_EN: rd_mux_s[0] = irq_en_r;
            default:     rd_mux_s = '0;
        endcase
    end

    // Registered read port; data holds while no read is issued.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rd_en_i;
            if (rd_en_i) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    matmul_csr_cycle_cnt #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (launch_s),
        .en_i   (busy_s),
        .cnt_o  (cnt_s)
    );

    assign rdata_o  = rdata_r;
    assign rvalid_o = rvalid_r;
    assign wr_err_o = wr_err_r;
    assign start_o  = start_r;
    assign busy_o   = busy_s;
    assign cfg_o    = ctrl_r;
    assign irq_o    = irq_r;

endmodule

// File: tb/tb_matmul_csr_ctrl.sv
// Self-checking bench for matmul_csr_ctrl: directed scenarios followed by random
// traffic, compared cycle by cycle against a register-level reference model.
module tb_matmul_csr_ctrl;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DIM_W   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CTRL_W  = 10 + 3 * DIM_W;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk, rst_ni, wr_en, rd_en, done, rvalid, wr_err, start, busy, irq;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wdata, rdata;
    logic [CTRL_W-1:0] cfg;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [CTRL_W-1:0] m_ctrl;
    logic              m_run, m_done, m_err, m_irq_en, m_irq;
    int                m_cycles;
    logic              exp_start, exp_wrerr, exp_rvalid;
    logic [DATA_W-1:0] exp_rdata;

    matmul_csr_ctrl #(
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .wr_en_i  (wr_en),
        .rd_en_i  (rd_en),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .rvalid_o (rvalid),
        .wr_err_o (wr_err),
        .done_i   (done),
        .start_o  (start),
        .busy_o   (busy),
        .cfg_o    (cfg),
        .irq_o    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] read_model(input logic [1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        case (a)
            2'd0:    v[CTRL_W-1:0] = m_ctrl;
            2'd1:    v[3:0] = {m_irq, m_err, m_done, m_run};
            2'd2:    v = DATA_W'(m_cycles);
            default: v[0] = m_irq_en;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_irq_en = 1'b0; m_irq = 1'b0; m_cycles = 0;
        exp_start = 1'b0; exp_wrerr = 1'b0; exp_rvalid = 1'b0; exp_rdata = '0;
    endtask

    task automatic check_outputs();
        check("start_o",  32'(start),  32'(exp_start));
        check("busy_o",   32'(busy),   32'(m_run));
        check("wr_err_o", 32'(wr_err), 32'(exp_wrerr));
        check("irq_o",    32'(irq),    32'(m_irq));
        check("cfg_o",    32'(cfg),    32'(m_ctrl));
        check("rvalid_o", 32'(rvalid), 32'(exp_rvalid));
        check("rdata_o",  rdata,       exp_rdata);
    endtask

    // One clock with the given host/core inputs, then model update and checks.
    task automatic step(input logic wr, input logic rd, input logic [1:0] a,
                        input logic [31:0] wd, input logic dn);
        logic launch, done_set, err_set, irq_next;
        wr_en = wr; rd_en = rd; addr = a; wdata = wd; done = dn;
        @(posedge clk);
        #1;
        irq_next   = m_done & m_irq_en;
        exp_rvalid = rd;
        if (rd) exp_rdata = read_model(a);
        launch = 1'b0; done_set = 1'b0; err_set = 1'b0;
        exp_start = 1'b0; exp_wrerr = 1'b0;
        if (m_run) begin
            if (m_cycles < CNT_MAX) m_cycles++;
            if (wr && a == 2'd0) begin
                exp_wrerr = 1'b1;
                err_set   = 1'b1;
            end
            if (dn) begin
                m_run     = 1'b0;
                m_ctrl[0] = 1'b0;
                done_set  = 1'b1;
            end
        end else if (wr && a == 2'd0) begin
            m_ctrl = wd[CTRL_W-1:0];
            if (wd[0]) begin
                m_run = 1'b1; launch = 1'b1; exp_start = 1'b1; m_cycles = 0;
            end
        end
        if (done_set) m_done = 1'b1;
        else if (launch || (wr && a == 2'd1 && wd[1])) m_done = 1'b0;
        if (err_set) m_err = 1'b1;
        else if (wr && a == 2'd1 && wd[2]) m_err = 1'b0;
        if (wr && a == 2'd3) m_irq_en = wd[0];
        m_irq = irq_next;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; wr_en = 1'b0; rd_en = 1'b0; done = 1'b0; addr = 2'd0; wdata = '0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        model_reset();
        check_outputs();
    endtask

    initial begin
        rst_ni = 1'b0; wr_en = 1'b0; rd_en = 1'b0; done = 1'b0; addr = 2'd0; wdata = '0;
        @(posedge clk);
        do_reset();

        // 1: reset in the middle of a run
        step(1'b1, 1'b0, 2'd0, 32'h0001, 1'b0);
        idle(5);
        do_reset();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cfg", 32'(cfg), 32'h0);
        step(1'b0, 1'b1, 2'd2, 32'h0, 1'b0);
        check("rst_cycles", rdata, 32'h0);

        // 2: launch and completion
        step(1'b1, 1'b0, 2'd0, 32'h3F01, 1'b0);
        check("launch_start", 32'(start), 32'h1);
        idle(10);
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        check("done_cfg0", 32'(cfg[0]), 32'h0);
        step(1'b0, 1'b1, 2'd1, 32'h0, 1'b0);
        check("done_status", rdata, 32'h2);
        idle(3);
        step(1'b0, 1'b1, 2'd2, 32'h0, 1'b0);
        check("run_cycles", rdata, 32'd11);

        // 3: locked CTRL write, then clear err_sticky
        step(1'b1, 1'b0, 2'd0, 32'h3F01, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 2'd0, 32'h00C0, 1'b0);
        check("lock_cfg", 32'(cfg), 32'h3F01);
        check("lock_err", 32'(wr_err), 32'h1);
        step(1'b0, 1'b1, 2'd1, 32'h0, 1'b0);
        check("lock_status", rdata, 32'h5);
        step(1'b1, 1'b1, 2'd1, 32'h4, 1'b0);
        step(1'b0, 1'b1, 2'd1, 32'h0, 1'b0);
        check("err_cleared", rdata, 32'h1);
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);

        // 4: interrupt enabled, cleared, then disabled
        step(1'b1, 1'b0, 2'd3, 32'h1, 1'b0);
        step(1'b1, 1'b0, 2'd0, 32'h0101, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        check("irq_lag", 32'(irq), 32'h0);
        idle(1);
        check("irq_set", 32'(irq), 32'h1);
        step(1'b1, 1'b0, 2'd1, 32'h2, 1'b0);
        idle(1);
        check("irq_clr", 32'(irq), 32'h0);
        step(1'b1, 1'b0, 2'd3, 32'h0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 32'h0001, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        idle(3);
        check("irq_masked", 32'(irq), 32'h0);

        // 5: read and write of IRQ_EN in the same cycle
        step(1'b1, 1'b1, 2'd3, 32'h1, 1'b0);
        check("rdw_old", rdata, 32'h0);
        check("rdw_valid", 32'(rvalid), 32'h1);
        step(1'b0, 1'b1, 2'd3, 32'h0, 1'b0);
        check("rdw_new", rdata, 32'h1);

        // 6: done in IDLE, saturation, write colliding with done
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        check("idle_done_busy", 32'(busy), 32'h0);
        step(1'b0, 1'b1, 2'd1, 32'h0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 32'h0001, 1'b0);
        idle(20);
        step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 2'd2, 32'h0, 1'b0);
        check("cnt_sat", rdata, 32'd15);
        step(1'b1, 1'b0, 2'd0, 32'h0F03, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 2'd0, 32'h0055, 1'b1);
        check("collide_err", 32'(wr_err), 32'h1);
        check("collide_cfg", 32'(cfg), 32'h0F02);
        check("collide_busy", 32'(busy), 32'h0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        r_wr, r_rd, r_dn;
            logic [1:0]  r_a;
            logic [31:0] r_wd;
            r_wr = ($urandom_range(0, 2) == 0);
            r_rd = ($urandom_range(0, 1) == 1);
            r_a  = 2'($urandom_range(0, 3));
            r_wd = $urandom;
            if (r_a == 2'd0 && $urandom_range(0, 1) == 1) r_wd[0] = 1'b1;
            r_dn = ($urandom_range(0, 11) == 0);
            step(r_wr, r_rd, r_a, r_wd, r_dn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_csr_ctrl.md
Name: matmul_csr_ctrl

Overview:
Parametrised control/status register block for the matrix-multiply core. It succeeds the fixed 16-bit control register with an addressed register file (CTRL, STATUS, CYCLES, IRQ_EN) and a run-state FSM that turns a start write into a single-cycle launch pulse. It locks configuration while the core runs and flags illegal writes. It also counts run cycles and raises a maskable done interrupt. It sits between the host bus and the core datapath.

Parameters:
DATA_W, 32, host bus data width; must be >= CTRL_W
DIM_W, 2, width of each dimension field (n, k, m)
CNT_W, 32, cycle counter width; must be <= DATA_W

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
wr_en_i  in  1  host write strobe, one access per cycle
rd_en_i  in  1  host read strobe
addr_i  in  2  register select: 0 CTRL, 1 STATUS, 2 CYCLES, 3 IRQ_EN
wdata_i  in  DATA_W  write data
rdata_o  out  DATA_W  read data, registered
rvalid_o  out  1  read data valid, one cycle after rd_en_i
wr_err_o  out  1  one-cycle pulse when a write is rejected
done_i  in  1  core completion pulse
start_o  out  1  one-cycle launch pulse to the core
busy_o  out  1  high while the FSM is in RUN
cfg_o  out  CTRL_W  live CTRL contents to the core
irq_o  out  1  done interrupt, level

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk_i. It is the same whether the FSM is idle or mid-run.
- Reset values: every register, every output and the cycle counter are 0. The FSM returns to IDLE.
- CTRL layout, with CTRL_W = 10 + 3*DIM_W:
  - bit 0: start
  - bit 1: mode
  - [3:2]: write_target
  - [5:4]: read_target
  - [7:6]: dataflow
  - then dim_n, dim_k and dim_m, DIM_W bits each, in that order
  - then reload_a, then reload_b in the top bit
  - wdata_i bits at or above CTRL_W are ignored.
- STATUS is read-only except for write-1-to-clear bits:
  - bit 0: busy
  - bit 1: done_sticky (W1C)
  - bit 2: err_sticky (W1C)
  - bit 3: irq pending
- CYCLES is read-only and holds the run cycle count, zero-extended to DATA_W.
- IRQ_EN: bit 0 is read/write. All other bits read 0.
- FSM states are IDLE and RUN.
- IDLE -> RUN:
  - Trigger: a CTRL write with wdata_i[0] = 1.
  - On the same edge, CTRL is loaded, start_o is asserted for exactly the next cycle, the cycle counter clears to 0, and done_sticky clears.
  - A CTRL write with start = 0 in IDLE only updates CTRL.
- RUN:
  - The cycle counter increments every cycle and saturates at all-ones.
  - busy_o = 1.
- RUN -> IDLE: on done_i. On that edge:
  - CTRL bit 0 (start) clears.
  - done_sticky sets.
  - The counter freezes and holds its value until the next start.
- done_i in IDLE is ignored.
- Write lock in RUN:
  - Any CTRL write is rejected. CTRL is unchanged, wr_err_o pulses for the next cycle, and err_sticky sets.
  - This includes a CTRL write in the same cycle as done_i, because the decision uses the current state.
  - Writes to STATUS and IRQ_EN are accepted in any state.
  - Writes to CYCLES are ignored and raise no error.
- W1C on STATUS:
  - If set and clear of done_sticky coincide, set wins.
  - The same priority applies to err_sticky.
- Reads:
  - rdata_o and rvalid_o are registered, with 1-cycle latency.
  - A read and a write in the same cycle are both serviced. The read returns the pre-write value.
  - rdata_o holds its last value when rvalid_o = 0.
- irq_o = done_sticky & irq_en, registered. It therefore rises one cycle after done_sticky sets.

Decomposition:
- Package matmul_csr_pkg holds:
  - the address constants ADDR_CTRL, ADDR_STATUS, ADDR_CYCLES, ADDR_IRQ_EN
  - the STATUS bit indices
  - the CTRL field offsets as functions of DIM_W
  - the FSM state enum {IDLE, RUN}
- One sub-module: matmul_csr_cycle_cnt, a saturating counter with clear and enable inputs, of width CNT_W.

Test Plan:
1. Reset mid-run: write CTRL=0x0001, wait 5 cycles, pull rst_ni low for one edge -> busy_o, start_o, irq_o, cfg_o and CYCLES all read 0; state is IDLE.
2. Launch and completion:
   - Stimulus: write CTRL=0x3F01 (DIM_W=2), wait 10 cycles, pulse done_i.
   - start_o is high exactly 1 cycle and busy_o is high during RUN.
   - On the done edge: cfg_o[0] = 0 and STATUS reads 0x2.
   - CYCLES reads the number of clocks between the launch edge and the done edge, then holds.
3. Locked write: in RUN, write CTRL=0x00C0 -> cfg_o unchanged, wr_err_o high 1 cycle, STATUS bit 2 = 1. Then write STATUS=0x4 -> bit 2 = 0.
4. Interrupt:
   - With IRQ_EN=1, complete a run -> irq_o = 1 one cycle after done_sticky sets.
   - Write STATUS=0x2 -> irq_o = 0 next cycle.
   - With IRQ_EN=0, irq_o stays 0.
5. Read-during-write: same cycle, write IRQ_EN=1 and read IRQ_EN -> rdata_o = 0 with rvalid_o = 1. The next read returns 1.
6. Boundaries:
   - done_i pulsed in IDLE -> no state change, STATUS unchanged.
   - Counter saturation with CNT_W=4: hold RUN for 20 cycles -> CYCLES = 15.
   - Write CTRL in the same cycle as done_i -> write rejected, wr_err_o pulses.
